// File: rtl/rs232_pkg.sv
// Shared definitions for the rs232 transmit-side arbiters: FSM encoding,
// default line width and a one-hot to index helper.
package rs232_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int MAX_REQ        = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_HOLD      = 3'd4
  } arb_state_e;

  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rs232_tx_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or after the
// pointer, wrapping past the top index, returned one-hot.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);

  localparam int SW = PW + 1;

  logic [SW-1:0] sum;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      // ptr + i never exceeds 2N-2, so one subtraction is enough to wrap.
      sum = {1'b0, ptr_i} + SW'(i);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      idx = sum[PW-1:0];
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Round-robin sequencer sharing one rs232 transmitter between N_REQ byte
// sources, with a packet lock that a silent owner loses after LOCK_TO cycles.
module rs232_tx_arbiter
  import rs232_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int LOCK_TO = 1023
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [N_REQ-1:0]        req_valid_in,
  input  logic [N_REQ*DATA_W-1:0] req_data_in,
  input  logic [N_REQ-1:0]        req_last_in,
  output logic [N_REQ-1:0]        req_ack_out,
  output logic [N_REQ-1:0]        grant_out,
  output logic [DATA_W-1:0]       tx_data_out,
  output logic                    tx_start_out,
  input  logic                    tx_busy_in
);

  localparam int PW    = $clog2(N_REQ);
  localparam int CNT_W = $clog2(LOCK_TO + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_TO);

  arb_state_e        state_q;
  logic [N_REQ-1:0]  grant_q;
  logic [PW-1:0]     gidx_q;
  logic [PW-1:0]     ptr_q;
  logic              last_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_start_q;
  logic [N_REQ-1:0]  ack_q;

  logic [N_REQ-1:0]  pick;
  logic [PW-1:0]     pick_idx;
  logic [PW-1:0]     ptr_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [DATA_W-1:0] tx_byte_d;
  logic              ack_cycle;

  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req_i   (req_valid_in),
    .ptr_i   (ptr_q),
    .grant_o (pick)
  );

  assign pick_idx  = PW'(onehot_to_idx(MAX_REQ'(pick)));
  assign ptr_d     = (gidx_q == PW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
  assign cnt_d     = (cnt_q == LOCK_MAX) ? cnt_q : cnt_q + 1'b1;
  // The requester still shows the acked byte during the ack pulse, so
  // IDLE and HOLD must not look at valid in that cycle.
  assign ack_cycle = |ack_q;

  always_comb begin
    tx_byte_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gidx_q == PW'(i)) tx_byte_d = req_data_in[i*DATA_W +: DATA_W];
    end
  end

  // NOTE: every register here uses <= so all of them see the pre-edge
  // values of one another, regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      ptr_q      <= '0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      ack_q      <= '0;
    end else begin
      tx_start_q <= 1'b0;
      ack_q      <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (!ack_cycle && |req_valid_in) begin
            grant_q <= pick;
            gidx_q  <= pick_idx;
            state_q <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (!tx_busy_in) begin
            tx_data_q  <= tx_byte_d;
            tx_start_q <= 1'b1;
            last_q     <= req_last_in[gidx_q];
            state_q    <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (tx_busy_in) state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!tx_busy_in) begin
            ack_q <= grant_q;
            cnt_q <= '0;
            if (last_q) begin
              ptr_q   <= ptr_d;
              grant_q <= '0;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!ack_cycle) begin
            if (req_valid_in[gidx_q]) begin
              cnt_q   <= '0;
              state_q <= S_LAUNCH;
            end else if (cnt_d == LOCK_MAX) begin
              cnt_q   <= '0;
              ptr_q   <= ptr_d;
              grant_q <= '0;
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ack_out  = ack_q;
  assign grant_out    = grant_q;
  assign tx_data_out  = tx_data_q;
  assign tx_start_out = tx_start_q;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Directed bench for rs232_tx_arbiter: queued requesters, a fixed-length
// transmitter model, and launch/ack logs compared against hand-derived values.
module tb_rs232_tx_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int LTO = 8;
  localparam int F   = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   valid = '0;
  logic [N-1:0]   last  = '0;
  logic [N*W-1:0] data  = '0;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic [W-1:0]   txd;
  logic           txs;
  logic           mbusy = 1'b0;
  logic           fbusy = 1'b0;
  logic           tx_busy;

  assign tx_busy = mbusy | fbusy;

  rs232_tx_arbiter #(.N_REQ(N), .DATA_W(W), .LOCK_TO(LTO)) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .req_valid_in (valid),
    .req_data_in  (data),
    .req_last_in  (last),
    .req_ack_out  (ack),
    .grant_out    (grant),
    .tx_data_out  (txd),
    .tx_start_out (txs),
    .tx_busy_in   (tx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } item_t;

  item_t rq[N][$];
  int l_idx[$], l_dat[$], l_cyc[$], a_idx[$], a_cyc[$];
  int fcnt = 0;
  int last_fall = 0;
  int total = 0;
  int bad = 0;

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Requesters: present queue head, pop it during the ack cycle.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      valid[i] = rq[i].size() > 0;
      last[i]  = (rq[i].size() > 0) ? rq[i][0].l : 1'b0;
      data[i*W +: W] = (rq[i].size() > 0) ? rq[i][0].d : '0;
    end
  end

  // Transmitter: busy from the start pulse for F cycles.
  always @(negedge clk) begin
    if (txs) begin
      mbusy = 1'b1;
      fcnt  = F;
    end else if (mbusy) begin
      fcnt = fcnt - 1;
      if (fcnt == 0) begin
        mbusy     = 1'b0;
        last_fall = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (txs) begin
      l_idx.push_back(oh2i(grant));
      l_dat.push_back(int'(txd));
      l_cyc.push_back(cyc);
    end
    if (|ack) begin
      a_idx.push_back(oh2i(ack));
      a_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int r, input logic [W-1:0] d, input logic l);
    item_t it;
    it.d = d;
    it.l = l;
    rq[r].push_back(it);
  endtask

  task automatic clear_logs();
    l_idx.delete(); l_dat.delete(); l_cyc.delete();
    a_idx.delete(); a_cyc.delete();
  endtask

  task automatic wait_acks(input int n);
    int b;
    b = 0;
    while (a_idx.size() < n && b < 2000) begin
      @(posedge clk);
      b++;
    end
    #1;
    check("ack_count", a_idx.size(), n);
  endtask

  task automatic wait_launch();
    int b;
    b = 0;
    while (l_idx.size() == 0 && b < 2000) begin
      @(posedge clk);
      b++;
    end
    check("launch_seen", l_idx.size(), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, a, t, n_ack;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_start", txs, 0);
    check("rst_data", txd, 0);
    check("rst_ack", ack, 0);

    // Single byte from requester 1; valid appears in cycle k.
    @(posedge clk); #1;
    clear_logs();
    k = cyc;
    push(1, 8'hA5, 1'b1);
    @(negedge clk);
    check("t1_grant_c0", grant, 0);
    @(negedge clk);
    check("t1_grant_c1", grant, 4'b0010);
    check("t1_start_c1", txs, 0);
    @(negedge clk);
    check("t1_start_c2", txs, 1);
    check("t1_data_c2", txd, 8'hA5);
    wait_acks(1);
    check("t1_launch_cyc", l_cyc[0] - k, 2);
    check("t1_ack_idx", a_idx[0], 1);
    check("t1_ack_after_fall", a_cyc[0] - last_fall, 1);
    @(negedge clk);
    check("t1_grant_idle", grant, 0);
    repeat (10) @(posedge clk);
    check("t1_single_ack", a_idx.size(), 1);

    // Packet lock: pointer is 2, so requester 2's packet goes first and whole.
    @(posedge clk); #1;
    clear_logs();
    push(2, 8'h11, 1'b0);
    push(2, 8'h22, 1'b0);
    push(2, 8'h33, 1'b1);
    push(0, 8'h44, 1'b1);
    wait_acks(4);
    check("lk_idx0", l_idx[0], 2);
    check("lk_idx1", l_idx[1], 2);
    check("lk_idx2", l_idx[2], 2);
    check("lk_idx3", l_idx[3], 0);
    check("lk_dat0", l_dat[0], 8'h11);
    check("lk_dat1", l_dat[1], 8'h22);
    check("lk_dat2", l_dat[2], 8'h33);
    check("lk_dat3", l_dat[3], 8'h44);
    // Ack cycle, HOLD samples valid, LAUNCH, then the start pulse.
    check("lk_b2b_1", l_cyc[1] - a_cyc[0], 3);
    check("lk_b2b_2", l_cyc[2] - a_cyc[1], 3);
    check("lk_after_last", l_cyc[3] - a_cyc[2], 3);

    // Pointer is now 1: simultaneous 0,1,3 are served 1,3,0.
    @(posedge clk); #1;
    clear_logs();
    push(0, 8'h50, 1'b1);
    push(1, 8'h51, 1'b1);
    push(3, 8'h53, 1'b1);
    wait_acks(3);
    check("rr_idx0", l_idx[0], 1);
    check("rr_idx1", l_idx[1], 3);
    check("rr_idx2", l_idx[2], 0);
    check("rr_dat1", l_dat[1], 8'h53);
    check("rr_gap", l_cyc[2] - a_cyc[1], 3);

    // Lock timeout: requester 3 goes silent after a last=0 byte.
    @(posedge clk); #1;
    clear_logs();
    push(3, 8'h77, 1'b0);
    wait_acks(1);
    a = a_cyc[0];
    push(1, 8'h88, 1'b1);
    repeat (8) @(negedge clk);
    check("to_cyc_ref", cyc - a, 8);
    check("to_grant_held", grant, 4'b1000);
    check("to_no_launch", l_idx.size(), 1);
    @(negedge clk);
    check("to_grant_drop", grant, 0);
    wait_acks(2);
    check("to_next_idx", l_idx[1], 1);
    check("to_next_dat", l_dat[1], 8'h88);
    check("to_next_cyc", l_cyc[1] - a, 11);

    // Busy transmitter held high for 50 cycles from the request.
    @(posedge clk); #1;
    clear_logs();
    fbusy = 1'b1;
    push(2, 8'h5A, 1'b1);
    repeat (50) @(negedge clk);
    check("bz_no_start", l_idx.size(), 0);
    check("bz_grant", grant, 4'b0100);
    t = cyc;
    fbusy = 1'b0;
    @(negedge clk);
    check("bz_start", txs, 1);
    check("bz_data", txd, 8'h5A);
    wait_acks(1);
    check("bz_start_cyc", l_cyc[0] - t, 1);

    // Reset while the frame is in WAIT_DONE.
    @(posedge clk); #1;
    clear_logs();
    push(0, 8'hC3, 1'b1);
    wait_launch();
    #1;
    rst = 1'b1;
    rq[0].delete();
    n_ack = a_idx.size();
    @(negedge clk);
    @(negedge clk);
    check("mr_grant", grant, 0);
    check("mr_start", txs, 0);
    check("mr_data", txd, 0);
    check("mr_ack", ack, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    check("mr_no_ack", a_idx.size(), n_ack);

    // Pointer back at 0: requesters 3 and 1 are served 1 then 3.
    @(posedge clk); #1;
    clear_logs();
    push(3, 8'hE3, 1'b1);
    push(1, 8'hE1, 1'b1);
    wait_acks(2);
    check("mr_ptr_idx0", l_idx[0], 1);
    check("mr_ptr_idx1", l_idx[1], 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
